hold_pulse_gen: RTL and testbench

//  Transmit side of the hold-high signalling line: on request, drives o_data high for a

---
 rtl/hold_sig_pkg.sv | 19 +
 rtl/hold_cnt.sv | 26 ++
 rtl/hold_pulse_gen.sv | 112 +++++++++++
 tb/tb_hold_pulse_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hold_sig_pkg.sv
// Shared definitions for the hold-high signalling line (pulse generator and hold detector).
// State encodings, default detector threshold and the effective-length rule.
package hold_sig_pkg;

    typedef enum logic [1:0] {
        StRst  = 2'd0,
        StIdle = 2'd1,
        StHigh = 2'd2,
        StGap  = 2'd3
    } hold_state_e;

    localparam int unsigned CntOnesecDefault = 1_000_000;

    // A requested length of 0 means "just long enough to trip the detector".
    function automatic int unsigned len_sel(input int unsigned len, input int unsigned cnt_onesec);
        return (len == 0) ? cnt_onesec + 2 : len;
    endfunction

endpackage

// File: rtl/hold_cnt.sv
// Up counter with synchronous clear, enable and terminal-match flag.
// Shared between the HIGH and GAP phases of hold_pulse_gen.
module hold_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_match,
    output logic         o_hit
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign o_hit = (cnt_q == i_match);

endmodule

// File: rtl/hold_pulse_gen.sv
// Hold-high line transmitter: drives o_data high for a programmed length, then a forced gap.
// Optional abort input is enabled by defining HOLD_GEN_ABORT_EN.
module hold_pulse_gen
    import hold_sig_pkg::*;
#(
    parameter int unsigned CNT_ONESEC = CntOnesecDefault,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned CNT_W      = $clog2(CNT_ONESEC + 3)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
`ifdef HOLD_GEN_ABORT_EN
    input  logic             i_abort,
`endif
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_data,
    output logic             o_done,
    output logic             o_aborted
);

    hold_state_e      state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_match;
    logic             data_q, data_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             abort_req;
    logic             cnt_hit;
    logic             cnt_clr;
    logic             cnt_en;

`ifdef HOLD_GEN_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        unique case (state_q)
            StRst:  state_d = StIdle;
            StIdle: begin
                if (i_start) begin
                    state_d   = StHigh;
                    len_d     = CNT_W'(len_sel(32'(i_len), CNT_ONESEC));
                    aborted_d = 1'b0;
                end
            end
            // Abort wins over a coincident normal end so it is reported.
            StHigh: begin
                if (abort_req) begin
                    state_d   = StGap;
                    aborted_d = 1'b1;
                end else if (cnt_hit) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_hit) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StRst;
        endcase
    end

    assign data_d    = (state_d == StHigh);
    assign cnt_match = (state_q == StHigh) ? (len_q - CNT_W'(1)) : CNT_W'(GAP_CYCLES - 1);
    assign cnt_clr   = (state_d != state_q);
    assign cnt_en    = (state_q == StHigh) || (state_q == StGap);

    hold_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (cnt_clr),
        .i_en    (cnt_en),
        .i_match (cnt_match),
        .o_hit   (cnt_hit)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StRst;
            len_q     <= '0;
            data_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            data_q    <= data_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign o_ready   = (state_q == StIdle);
    assign o_busy    = (state_q == StHigh) || (state_q == StGap);
    assign o_data    = data_q;
    assign o_done    = done_q;
    assign o_aborted = aborted_q;

endmodule

// File: tb/tb_hold_pulse_gen.sv
// Randomized self-checking bench for hold_pulse_gen against an interval-based reference model.
module tb_hold_pulse_gen;

    localparam int unsigned CNT_ONESEC = 8;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned CNT_W      = $clog2(CNT_ONESEC + 3);
`ifdef HOLD_GEN_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_start;
    logic [CNT_W-1:0] i_len;
    logic             abort_drv;
    logic             o_ready, o_busy, o_data, o_done, o_aborted;

    int n_checks = 0;
    int n_errors = 0;

    // Model: every pulse is an interval [k_start, hi_end) high, then gap until idle_at.
    int edge_n       = 0;
    int k_start      = 0;
    int hi_end       = 0;
    int idle_at      = 1 << 30;
    bit pulse_active = 1'b0;
    bit abort_flag   = 1'b0;
    int accepts      = 0;
    int rises        = 0;
    bit prev_data    = 1'b0;

    hold_pulse_gen #(
        .CNT_ONESEC (CNT_ONESEC),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_len     (i_len),
`ifdef HOLD_GEN_ABORT_EN
        .i_abort   (abort_drv),
`endif
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_data    (o_data),
        .o_done    (o_done),
        .o_aborted (o_aborted)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
        end
    endtask

    function automatic bit exp_ready(input int n);
        return n >= idle_at;
    endfunction

    function automatic bit exp_busy(input int n);
        return pulse_active && n >= k_start && n < idle_at;
    endfunction

    function automatic bit exp_data(input int n);
        return pulse_active && n >= k_start && n < hi_end;
    endfunction

    function automatic bit exp_done(input int n);
        return pulse_active && n == idle_at;
    endfunction

    function automatic bit exp_aborted(input int n);
        return abort_flag && n >= hi_end;
    endfunction

    function automatic int len_eff(input logic [CNT_W-1:0] l);
        return (l == 0) ? int'(CNT_ONESEC) + 2 : int'(l);
    endfunction

    // Apply the effect of the edge just taken, using the observable state before it.
    task automatic model_edge(input logic s, input logic [CNT_W-1:0] l, input logic a,
                              input logic r);
        int prev;
        prev = edge_n - 1;
        if (!r) begin
            idle_at      = edge_n + 1;
            pulse_active = 1'b0;
            abort_flag   = 1'b0;
        end else if (s && exp_ready(prev)) begin
            k_start      = edge_n;
            hi_end       = edge_n + len_eff(l);
            idle_at      = hi_end + int'(GAP_CYCLES);
            pulse_active = 1'b1;
            abort_flag   = 1'b0;
            accepts++;
        end else if (ABORT_EN && a && exp_data(prev)) begin
            hi_end     = edge_n;
            idle_at    = edge_n + int'(GAP_CYCLES);
            abort_flag = 1'b1;
        end
    endtask

    task automatic cycle(input logic s, input logic [CNT_W-1:0] l, input logic a, input logic r);
        i_start   = s;
        i_len     = l;
        abort_drv = a;
        i_rst_n   = r;
        @(posedge i_clk);
        edge_n++;
        model_edge(s, l, a, r);
        #1;
        check_eq("ready", int'(o_ready), int'(exp_ready(edge_n)));
        check_eq("busy", int'(o_busy), int'(exp_busy(edge_n)));
        check_eq("data", int'(o_data), int'(exp_data(edge_n)));
        check_eq("done", int'(o_done), int'(exp_done(edge_n)));
        check_eq("aborted", int'(o_aborted), int'(exp_aborted(edge_n)));
        if (o_data === 1'b1 && !prev_data) rises++;
        prev_data = (o_data === 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        i_start   = 1'b0;
        i_len     = '0;
        abort_drv = 1'b0;
        i_rst_n   = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        idle_cycles(2);

        // Default length, then short, single-clock and just-below-threshold pulses.
        cycle(1'b1, CNT_W'(0), 1'b0, 1'b1);
        idle_cycles(14);
        cycle(1'b1, CNT_W'(3), 1'b0, 1'b1);
        idle_cycles(7);
        cycle(1'b1, CNT_W'(1), 1'b0, 1'b1);
        idle_cycles(5);
        cycle(1'b1, CNT_W'(9), 1'b0, 1'b1);
        idle_cycles(13);

        // Continuous requests: no queueing while busy, i_len changes ignored mid-pulse.
        for (int i = 0; i < 40; i++) cycle(1'b1, CNT_W'(2), 1'b0, 1'b1);
        cycle(1'b1, CNT_W'(4), 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, CNT_W'(i + 7), 1'b0, 1'b1);
        idle_cycles(4);

        // Reset during the 5th high clock, then a full default pulse.
        cycle(1'b1, CNT_W'(0), 1'b0, 1'b1);
        idle_cycles(4);
        cycle(1'b0, '0, 1'b0, 1'b0);
        idle_cycles(2);
        cycle(1'b1, CNT_W'(0), 1'b0, 1'b1);
        idle_cycles(14);

`ifdef HOLD_GEN_ABORT_EN
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, CNT_W'(0), 1'b0, 1'b1);
        idle_cycles(2);
        cycle(1'b0, '0, 1'b1, 1'b1);
        idle_cycles(5);
        cycle(1'b1, CNT_W'(3), 1'b0, 1'b1);
        idle_cycles(1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        idle_cycles(5);
`endif

        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), CNT_W'($urandom_range(0, (1 << CNT_W) - 1)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 199) != 0));
        end
        idle_cycles(16);

        check_eq("pulses_vs_accepts", rises, accepts);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
